// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: state encodings, default timing constants and sizing helper for run_ctrl
package run_ctrl_pkg;
  typedef enum logic [1:0] {ST_RESET = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
  localparam int RST_CYCLES_DEF = 25;
  localparam int MAX_CYCLES_DEF = 1000;
  function automatic int seq_w(input int rst_cycles, input int n_ch, input int stagger);
    return $clog2(rst_cycles + (n_ch - 1) * stagger + 1);
  endfunction
endpackage

// File: rtl/run_ctrl_if.sv
// run_ctrl_if: run-control handshake and status bundle between the system top and run_ctrl
interface run_ctrl_if #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 32
);
  logic             pause_in;
  logic             halt_in;
  logic             restart_in;
  logic [N_CH-1:0]  core_rst_out;
  logic             running_out;
  logic             done_out;
  logic             halted_out;
  logic             timeout_out;
  logic [CNT_W-1:0] cycle_cnt_out;
  modport master (
    output pause_in, halt_in, restart_in,
    input  core_rst_out, running_out, done_out, halted_out, timeout_out, cycle_cnt_out
  );
  modport slave (
    input  pause_in, halt_in, restart_in,
    output core_rst_out, running_out, done_out, halted_out, timeout_out, cycle_cnt_out
  );
endinterface

// File: rtl/run_ctrl_rst_stagger.sv
// rst_stagger: per-channel release comparators on the reset sequence count
module rst_stagger #(
  parameter int N_CH        = 2,
  parameter int RST_CYCLES  = 25,
  parameter int RST_STAGGER = 0,
  parameter int SEQ_W       = 5
) (
  input  logic [SEQ_W-1:0] seq_cnt,
  output logic [N_CH-1:0]  rel
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign rel[i] = int'(seq_cnt) >= RST_CYCLES + i * RST_STAGGER;
  end
endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: staggered reset release followed by a pausable, budgeted run counter with restart
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int N_CH         = 2,
  parameter int RST_CYCLES   = RST_CYCLES_DEF,
  parameter int RST_STAGGER  = 0,
  parameter int CNT_W        = 32,
  parameter int MAX_CYCLES   = MAX_CYCLES_DEF,
  parameter bit HOLD_ON_DONE = 1'b1
) (
  input logic       clk_in,
  input logic       rst_n_in,
  run_ctrl_if.slave bus
);
  localparam int SEQ_W    = seq_w(RST_CYCLES, N_CH, RST_STAGGER);
  localparam int REL_LAST = RST_CYCLES + (N_CH - 1) * RST_STAGGER;
  if (N_CH < 1 || RST_CYCLES < 1) begin : g_bad_cfg
    $error("run_ctrl: N_CH and RST_CYCLES must be at least 1");
  end
  if (CNT_W < 63 && longint'(MAX_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_max
    $error("run_ctrl: MAX_CYCLES does not fit in CNT_W bits");
  end
  state_t           state, state_nxt;
  logic [SEQ_W-1:0] seq_cnt, seq_inc, seq_d;
  logic [N_CH-1:0]  rel, core_d;
  logic [CNT_W-1:0] cnt_inc, cnt_d;
  logic             tmo, halted_d, timeout_d;
  rst_stagger #(
    .N_CH(N_CH), .RST_CYCLES(RST_CYCLES), .RST_STAGGER(RST_STAGGER), .SEQ_W(SEQ_W)
  ) u_stagger (
    .seq_cnt(seq_d),
    .rel    (rel)
  );
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state             <= ST_RESET;
      seq_cnt           <= '0;
      bus.core_rst_out  <= '1;
      bus.running_out   <= 1'b0;
      bus.done_out      <= 1'b0;
      bus.halted_out    <= 1'b0;
      bus.timeout_out   <= 1'b0;
      bus.cycle_cnt_out <= '0;
    end else begin
      state             <= state_nxt;
      seq_cnt           <= seq_d;
      bus.core_rst_out  <= core_d;
      bus.running_out   <= state_nxt == ST_RUN;
      bus.done_out      <= state_nxt == ST_DONE;
      bus.halted_out    <= halted_d;
      bus.timeout_out   <= timeout_d;
      bus.cycle_cnt_out <= cnt_d;
    end
  end
  // the counter only saturates when unlimited; a nonzero budget always stops it first
  always_comb begin
    seq_inc   = seq_cnt + SEQ_W'(1);
    cnt_inc   = &bus.cycle_cnt_out ? bus.cycle_cnt_out : bus.cycle_cnt_out + CNT_W'(1);
    tmo       = MAX_CYCLES != 0 && !bus.pause_in && cnt_inc == CNT_W'(MAX_CYCLES);
    state_nxt = state == ST_RESET ? (int'(seq_inc) >= REL_LAST ? ST_RUN : ST_RESET)
              : state == ST_RUN   ? (bus.halt_in || tmo ? ST_DONE : ST_RUN)
              : (bus.restart_in ? ST_RESET : ST_DONE);
  end
  always_comb begin
    seq_d     = state == ST_RESET ? seq_inc : '0;
    core_d    = state_nxt == ST_RESET ? ~rel
              : state_nxt == ST_DONE  ? {N_CH{HOLD_ON_DONE}} : '0;
    cnt_d     = state == ST_RUN  ? (!bus.halt_in && !bus.pause_in ? cnt_inc : bus.cycle_cnt_out)
              : state == ST_DONE ? (bus.restart_in ? '0 : bus.cycle_cnt_out)
              : bus.cycle_cnt_out;
    halted_d  = state == ST_RUN ? bus.halt_in
              : state == ST_DONE && !bus.restart_in && bus.halted_out;
    timeout_d = state == ST_RUN ? !bus.halt_in && tmo
              : state == ST_DONE && !bus.restart_in && bus.timeout_out;
  end
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: three run_ctrl configurations on shared stimulus against a behavioural model
module tb_run_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  run_ctrl_if #(.N_CH(2), .CNT_W(32)) ia ();
  run_ctrl_if #(.N_CH(4), .CNT_W(32)) ib ();
  run_ctrl_if #(.N_CH(1), .CNT_W(4))  ic ();
  run_ctrl #(.N_CH(2), .RST_CYCLES(run_ctrl_pkg::RST_CYCLES_DEF), .RST_STAGGER(0), .CNT_W(32),
             .MAX_CYCLES(run_ctrl_pkg::MAX_CYCLES_DEF), .HOLD_ON_DONE(1'b1))
    dut_a (.clk_in(clk), .rst_n_in(rst_n), .bus(ia));
  run_ctrl #(.N_CH(4), .RST_CYCLES(3), .RST_STAGGER(2), .CNT_W(32), .MAX_CYCLES(10), .HOLD_ON_DONE(1'b1))
    dut_b (.clk_in(clk), .rst_n_in(rst_n), .bus(ib));
  run_ctrl #(.N_CH(1), .RST_CYCLES(2), .RST_STAGGER(0), .CNT_W(4), .MAX_CYCLES(0), .HOLD_ON_DONE(1'b0))
    dut_c (.clk_in(clk), .rst_n_in(rst_n), .bus(ic));
  int errors = 0, checks = 0;
  int nch[3]  = '{2, 4, 1};
  int rstc[3] = '{run_ctrl_pkg::RST_CYCLES_DEF, 3, 2};
  int stag[3] = '{0, 2, 0};
  int cw[3]   = '{32, 32, 4};
  int maxc[3] = '{run_ctrl_pkg::MAX_CYCLES_DEF, 10, 0};
  int hold[3] = '{1, 1, 0};
  int mst[3];
  longint msc[3], mcnt[3];
  bit mh[3], mt[3];
  task automatic model_edge(input bit pp, input bit hh, input bit rr, input bit rn);
    for (int i = 0; i < 3; i++) begin
      if (!rn || (mst[i] == 2 && rr)) begin
        mst[i] = 0; msc[i] = 0; mcnt[i] = 0; mh[i] = 0; mt[i] = 0;
      end else if (mst[i] == 0) begin
        msc[i]++;
        if (msc[i] >= rstc[i] + (nch[i] - 1) * stag[i]) mst[i] = 1;
      end else if (mst[i] == 1) begin
        if (hh) begin
          mst[i] = 2; mh[i] = 1;
        end else if (!pp) begin
          if (!(maxc[i] == 0 && mcnt[i] == (longint'(1) << cw[i]) - 1)) mcnt[i]++;
          if (maxc[i] != 0 && mcnt[i] == maxc[i]) begin
            mst[i] = 2; mt[i] = 1;
          end
        end
      end
    end
  endtask
  function automatic logic [31:0] exp_core(input int i);
    logic [31:0] v = '0;
    for (int j = 0; j < nch[i]; j++)
      v[j] = mst[i] == 0 ? msc[i] < rstc[i] + j * stag[i] : mst[i] == 2 ? hold[i] != 0 : 1'b0;
    return v;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic check_all();
    chk("a.core", 32'(ia.core_rst_out), exp_core(0));
    chk("a.running", 32'(ia.running_out), 32'(mst[0] == 1));
    chk("a.done", 32'(ia.done_out), 32'(mst[0] == 2));
    chk("a.halted", 32'(ia.halted_out), 32'(mh[0]));
    chk("a.timeout", 32'(ia.timeout_out), 32'(mt[0]));
    chk("a.cnt", 32'(ia.cycle_cnt_out), 32'(mcnt[0]));
    chk("b.core", 32'(ib.core_rst_out), exp_core(1));
    chk("b.running", 32'(ib.running_out), 32'(mst[1] == 1));
    chk("b.done", 32'(ib.done_out), 32'(mst[1] == 2));
    chk("b.halted", 32'(ib.halted_out), 32'(mh[1]));
    chk("b.timeout", 32'(ib.timeout_out), 32'(mt[1]));
    chk("b.cnt", 32'(ib.cycle_cnt_out), 32'(mcnt[1]));
    chk("c.core", 32'(ic.core_rst_out), exp_core(2));
    chk("c.running", 32'(ic.running_out), 32'(mst[2] == 1));
    chk("c.done", 32'(ic.done_out), 32'(mst[2] == 2));
    chk("c.halted", 32'(ic.halted_out), 32'(mh[2]));
    chk("c.timeout", 32'(ic.timeout_out), 32'(mt[2]));
    chk("c.cnt", 32'(ic.cycle_cnt_out), 32'(mcnt[2]));
  endtask
  task automatic step(input bit pp, input bit hh, input bit rr, input bit rn);
    ia.pause_in = pp; ia.halt_in = hh; ia.restart_in = rr;
    ib.pause_in = pp; ib.halt_in = hh; ib.restart_in = rr;
    ic.pause_in = pp; ic.halt_in = hh; ic.restart_in = rr;
    rst_n = rn;
    @(posedge clk);
    model_edge(pp, hh, rr, rn);
    #1 check_all();
  endtask
  initial begin
    repeat (5) step(0, 0, 0, 0);
    chk("a.rst_core", 32'(ia.core_rst_out), 32'h3);
    chk("b.rst_core", 32'(ib.core_rst_out), 32'hf);
    for (int e = 1; e <= 1025; e++) begin
      step(0, 0, 0, 1);
      if (e == 3) chk("b.rel_e3", 32'(ib.core_rst_out), 32'he);
      if (e == 5) chk("b.rel_e5", 32'(ib.core_rst_out), 32'hc);
      if (e == 7) chk("b.rel_e7", 32'(ib.core_rst_out), 32'h8);
      if (e == 8) chk("b.run_e8", 32'(ib.running_out), 32'h0);
      if (e == 9) chk("b.rel_e9", 32'(ib.core_rst_out), 32'h0);
      if (e == 9) chk("b.run_e9", 32'(ib.running_out), 32'h1);
      if (e == 19) chk("b.tmo_e19", 32'(ib.timeout_out), 32'h1);
      if (e == 19) chk("b.cnt_e19", 32'(ib.cycle_cnt_out), 32'd10);
      if (e == 20) chk("c.sat", 32'(ic.cycle_cnt_out), 32'd15);
      if (e == 24) chk("a.core_e24", 32'(ia.core_rst_out), 32'h3);
      if (e == 25) chk("a.core_e25", 32'(ia.core_rst_out), 32'h0);
      if (e == 25) chk("a.run_e25", 32'(ia.running_out), 32'h1);
      if (e == 1024) chk("a.done_e1024", 32'(ia.done_out), 32'h0);
      if (e == 1025) chk("a.tmo_e1025", 32'(ia.timeout_out), 32'h1);
      if (e == 1025) chk("a.cnt_e1025", 32'(ia.cycle_cnt_out), 32'd1000);
      if (e == 1025) chk("a.hold_e1025", 32'(ia.core_rst_out), 32'h3);
    end
    step(0, 0, 1, 1);
    chk("c.restart_in_run", 32'(ic.running_out), 32'h1);
    chk("b.restart_core", 32'(ib.core_rst_out), 32'hf);
    repeat (9) step(0, 0, 0, 1);
    for (int k = 1; k <= 13; k++) step(k >= 4 && k <= 6, 0, 0, 1);
    chk("b.pause_tmo", 32'(ib.timeout_out), 32'h1);
    chk("b.pause_cnt", 32'(ib.cycle_cnt_out), 32'd10);
    step(0, 0, 1, 1);
    repeat (9) step(0, 0, 0, 1);
    for (int k = 1; k <= 7; k++) step(0, k == 7, 0, 1);
    chk("b.halt_flag", 32'(ib.halted_out), 32'h1);
    chk("b.halt_tmo", 32'(ib.timeout_out), 32'h0);
    chk("b.halt_cnt", 32'(ib.cycle_cnt_out), 32'd6);
    step(0, 0, 1, 1);
    chk("b.clr_halted", 32'(ib.halted_out), 32'h0);
    chk("b.clr_cnt", 32'(ib.cycle_cnt_out), 32'h0);
    repeat (9) step(0, 0, 0, 1);
    for (int k = 1; k <= 10; k++) step(0, k == 10, 0, 1);
    chk("b.coin_halted", 32'(ib.halted_out), 32'h1);
    chk("b.coin_tmo", 32'(ib.timeout_out), 32'h0);
    chk("b.coin_cnt", 32'(ib.cycle_cnt_out), 32'd9);
    repeat (600)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 8) == 0,
           $urandom_range(0, 200) != 0);
    step(0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    chk("b.restart_ignored", 32'(ib.running_out), 32'h1);
    step(0, 0, 0, 1);
    chk("b.cnt_pre_rst", 32'(ib.cycle_cnt_out), 32'd3);
    step(0, 0, 0, 0);
    chk("b.midrst_core", 32'(ib.core_rst_out), 32'hf);
    chk("b.midrst_run", 32'(ib.running_out), 32'h0);
    chk("b.midrst_cnt", 32'(ib.cycle_cnt_out), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
